// File: rtl/synapse_weight_feeder_pkg.sv
// synapse_weight_feeder_pkg: shared weight codes and feeder FSM state encoding
package synapse_weight_feeder_pkg;
    localparam int WEIGHT_BITS = 2;
    localparam logic [WEIGHT_BITS-1:0] W_ZERO = 2'b00;
    localparam logic [WEIGHT_BITS-1:0] W_POS1 = 2'b01;
    localparam logic [WEIGHT_BITS-1:0] W_NEG2 = 2'b10;
    localparam logic [WEIGHT_BITS-1:0] W_NEG1 = 2'b11;
    typedef enum logic [1:0] {
        S_EMPTY   = 2'd0,
        S_LOADING = 2'd1,
        S_READY   = 2'd2
    } state_t;
endpackage

// File: rtl/synapse_weight_feeder_weight_shift_reg.sv
// weight_shift_reg: byte-wide shift-in at the top, parallel weight word out, sync clear
module weight_shift_reg #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         en,
    input  logic [7:0]   din,
    output logic [W-1:0] q
);
    logic [W-1:0] q_q;
    always_ff @(posedge clk) begin
        if (clr) q_q <= '0;
        else if (en) q_q <= W'({din, q_q} >> 8);
    end
    assign q = q_q;
endmodule

// File: rtl/synapse_weight_feeder.sv
// synapse_weight_feeder: byte-serial 2-bit weight load, spike-gated wx bus for the adder tree
module synapse_weight_feeder
    import synapse_weight_feeder_pkg::*;
#(
    parameter int N_STAGE = 5,
    localparam int N_INPUTS = 2**N_STAGE,
    localparam int LOAD_BYTES = N_INPUTS / 4,
    localparam int CW = LOAD_BYTES > 1 ? $clog2(LOAD_BYTES) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load_start,
    input  logic                  load_valid,
    input  logic [7:0]            load_data,
    output logic                  load_ready,
    output logic                  weights_loaded,
    input  logic [N_INPUTS-1:0]   spikes_in,
    input  logic                  spikes_valid,
    output logic                  spikes_ready,
    output logic [2*N_INPUTS-1:0] wx_out,
    output logic                  wx_valid
);
    state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2*N_INPUTS-1:0] w, masked, wx_q;
    logic wxv_q, shift_en, last, accept;

    weight_shift_reg #(.W(2*N_INPUTS)) u_wreg (
        .clk(clk),
        .clr(reset | load_start),
        .en (shift_en),
        .din(load_data),
        .q  (w)
    );

    assign last = cnt_q == CW'(LOAD_BYTES - 1);

    // load_start wins from every state and discards any partial load
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shift_en = 1'b0;
        if (load_start) begin
            state_d = S_LOADING;
            cnt_d   = '0;
        end else if (state_q == S_LOADING && load_valid) begin
            shift_en = 1'b1;
            cnt_d    = last ? '0 : cnt_q + 1'b1;
            state_d  = last ? S_READY : S_LOADING;
        end
    end

    genvar i;
    for (i = 0; i < N_INPUTS; i++) begin : g_mask
        assign masked[WEIGHT_BITS*i +: WEIGHT_BITS] = spikes_in[i] ? w[WEIGHT_BITS*i +: WEIGHT_BITS] : W_ZERO;
    end

    assign accept = spikes_valid & spikes_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_EMPTY;
            cnt_q   <= '0;
            wx_q    <= '0;
            wxv_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wxv_q   <= accept;
            if (accept) wx_q <= masked;
        end
    end

    assign load_ready     = state_q == S_LOADING;
    assign weights_loaded = state_q == S_READY;
    assign spikes_ready   = state_q == S_READY && !load_start;
    assign wx_out         = wx_q;
    assign wx_valid       = wxv_q;
endmodule

// File: tb/tb_synapse_weight_feeder.sv
// tb_synapse_weight_feeder: directed + random stimulus against a behavioural feeder model
module tb_synapse_weight_feeder;
    localparam int NI = 8;
    localparam int NB = 2;
    logic clk = 1'b0, reset = 1'b1;
    logic load_start = 0, load_valid = 0, spikes_valid = 0;
    logic [7:0] load_data = 0;
    logic [NI-1:0] spikes_in = 0;
    logic load_ready, weights_loaded, spikes_ready, wx_valid;
    logic [2*NI-1:0] wx_out;
    int n_chk = 0, n_fail = 0;

    synapse_weight_feeder #(.N_STAGE(3)) dut (
        .clk(clk), .reset(reset), .load_start(load_start), .load_valid(load_valid),
        .load_data(load_data), .load_ready(load_ready), .weights_loaded(weights_loaded),
        .spikes_in(spikes_in), .spikes_valid(spikes_valid), .spikes_ready(spikes_ready),
        .wx_out(wx_out), .wx_valid(wx_valid)
    );

    always #5 clk = ~clk;

    function automatic int wval(input logic [1:0] c);
        return c == 2'b10 ? -2 : c == 2'b11 ? -1 : int'(c);
    endfunction

    function automatic int bus_sum(input logic [2*NI-1:0] v);
        int s = 0;
        for (int k = 0; k < NI; k++) s += wval(v[2*k +: 2]);
        return s;
    endfunction

    task automatic chk(input string nm, input logic signed [31:0] act, input logic signed [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
        end
    endtask

    // Model: phase 0=no weights, 1=collecting bytes, 2=weights usable
    int m_phase = 0;
    logic [7:0] m_bytes[$];
    logic [2*NI-1:0] m_w = 0, m_wx = 0;
    logic m_wxv = 0;
    int m_sum = 0;

    always @(posedge clk) begin
        if (reset) begin
            m_phase = 0; m_bytes.delete(); m_w = 0; m_wx = 0; m_wxv = 0; m_sum = 0;
        end else begin
            m_wxv = m_phase == 2 && spikes_valid && !load_start;
            if (m_wxv) begin
                m_sum = 0;
                for (int k = 0; k < NI; k++) begin
                    m_wx[2*k +: 2] = spikes_in[k] ? m_w[2*k +: 2] : 2'b00;
                    if (spikes_in[k]) m_sum += wval(m_w[2*k +: 2]);
                end
            end
            if (load_start) begin
                m_phase = 1; m_bytes.delete();
            end else if (m_phase == 1 && load_valid) begin
                m_bytes.push_back(load_data);
                if (m_bytes.size() == NB) begin
                    for (int b = 0; b < NB; b++) m_w[8*b +: 8] = m_bytes[b];
                    m_phase = 2;
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("load_ready", 32'(load_ready), 32'(m_phase == 1));
        chk("weights_loaded", 32'(weights_loaded), 32'(m_phase == 2));
        chk("spikes_ready", 32'(spikes_ready), 32'(m_phase == 2 && !load_start));
        chk("wx_valid", 32'(wx_valid), 32'(m_wxv));
        chk("wx_out", 32'(wx_out), 32'(m_wx));
        if (wx_valid) chk("wx_sum", bus_sum(wx_out), m_sum);
    end

    task automatic cyc(input logic ls, input logic lv, input logic [7:0] ld, input logic sv, input logic [7:0] sp);
        load_start = ls; load_valid = lv; load_data = ld; spikes_valid = sv; spikes_in = sp;
        @(posedge clk); #2;
        load_start = 0; load_valid = 0; load_data = 0; spikes_valid = 0; spikes_in = 0;
    endtask

    task automatic load2(input logic [7:0] b0, input logic [7:0] b1);
        cyc(1, 0, 0, 0, 0);
        cyc(0, 1, b0, 0, 0);
        cyc(0, 1, b1, 0, 0);
    endtask

    task automatic spike_lit(input logic [7:0] sp, input logic [15:0] exp_wx, input int exp_sum);
        cyc(0, 0, 0, 1, sp);
        @(negedge clk);
        chk("lit_wx_valid", 32'(wx_valid), 1);
        chk("lit_wx_out", 32'(wx_out), 32'(exp_wx));
        chk("lit_sum", bus_sum(wx_out), exp_sum);
        @(posedge clk); #2;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #2 reset = 0;
        @(negedge clk);
        chk("rst_outputs", 32'({load_ready, weights_loaded, spikes_ready, wx_valid, wx_out}), 0);
        cyc(0, 1, 8'hAB, 1, 8'hFF);
        @(negedge clk);
        chk("empty_ignore", 32'({load_ready, weights_loaded, wx_valid, wx_out}), 0);
        load2(8'h55, 8'h55);
        @(negedge clk);
        chk("lit_loaded", 32'(weights_loaded), 1);
        spike_lit(8'hFF, 16'h5555, 8);
        @(negedge clk);
        chk("lit_pulse_one", 32'(wx_valid), 0);
        load2(8'hFF, 8'hFF);
        spike_lit(8'h0F, 16'h00FF, -4);
        spike_lit(8'h00, 16'h0000, 0);
        cyc(1, 0, 0, 0, 0);
        cyc(0, 1, 8'hAA, 0, 0);
        cyc(1, 1, 8'h77, 0, 0);
        cyc(0, 1, 8'h01, 0, 0);
        @(negedge clk);
        chk("lit_restart_partial", 32'(weights_loaded), 0);
        cyc(0, 1, 8'h00, 0, 0);
        @(negedge clk);
        chk("lit_restart_done", 32'(weights_loaded), 1);
        spike_lit(8'h01, 16'h0001, 1);
        load_start = 1; spikes_valid = 1; spikes_in = 8'hFF;
        #1 chk("lit_collide_ready", 32'(spikes_ready), 0);
        @(posedge clk); #2;
        load_start = 0; spikes_valid = 0; spikes_in = 0;
        @(negedge clk);
        chk("lit_collide_state", 32'({load_ready, weights_loaded, wx_valid}), 32'b100);
        cyc(0, 1, 8'h12, 0, 0);
        reset = 1;
        @(posedge clk); #2 reset = 0;
        @(negedge clk);
        chk("lit_midload_rst", 32'({load_ready, weights_loaded, spikes_ready, wx_valid, wx_out}), 0);
        load2(8'h99, 8'h99);
        spike_lit(8'hFF, 16'h9999, -4);
        for (int n = 0; n < 600; n++) begin
            reset = $urandom_range(0, 59) == 0;
            cyc($urandom_range(0, 11) == 0, $urandom_range(0, 2) != 0, 8'($urandom),
                $urandom_range(0, 1) == 1, 8'($urandom));
            reset = 0;
        end
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
